// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing source: pixel-rate strobe, scan counters, sync/blank decode and a
// delay line that re-aligns sync/blank with the registered colour returned by the mapper.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned PIPE_DLY  = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] R_in,
  input  logic [7:0] G_in,
  input  logic [7:0] B_in,
  output logic       pix_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_FIRST = H_VISIBLE + H_FP;
  localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_VISIBLE + V_FP;
  localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SR_W     = 3 * PIPE_DLY;

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             ce_nxt;
  logic             last_h;
  logic             last_v;
  logic             hs_raw;
  logic             vs_raw;
  logic             blank_n_raw;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  shift_in;
  logic             feed_blank_n;

  always_comb begin
    div_nxt = (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + DIV_W'(1);
    ce_nxt  = (div_nxt == DIV_W'(CLK_DIV - 1));
    last_h  = (DrawX == 10'(H_TOTAL - 1));
    last_v  = (DrawY == 10'(V_TOTAL - 1));
  end

  // Clock divider; strobe and pixel clock are registered so they line up with div
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div         <= '0;
      pix_ce      <= 1'b0;
      VGA_CLK     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_nxt;
      pix_ce      <= ce_nxt;
      VGA_CLK     <= (div_nxt >= DIV_W'(CLK_DIV / 2));
      frame_start <= ce_nxt && last_h && last_v;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      DrawX <= '0;
      DrawY <= '0;
    end else if (pix_ce) begin
      if (last_h) begin
        DrawX <= '0;
        DrawY <= last_v ? '0 : DrawY + 10'd1;
      end else begin
        DrawX <= DrawX + 10'd1;
      end
    end
  end

  always_comb begin
    hs_raw      = !((DrawX >= 10'(HS_FIRST)) && (DrawX <= 10'(HS_LAST)));
    vs_raw      = !((DrawY >= 10'(VS_FIRST)) && (DrawY <= 10'(VS_LAST)));
    blank_n_raw = (DrawX < 10'(H_VISIBLE)) && (DrawY < 10'(V_VISIBLE));
  end

  // Each 3-bit group is {hs, vs, blank_n}; group 0 is the newest stage
  if (PIPE_DLY == 1) begin : g_dly_one
    assign shift_in = {hs_raw, vs_raw, blank_n_raw};
  end else begin : g_dly_multi
    assign shift_in = {sr[SR_W-4:0], hs_raw, vs_raw, blank_n_raw};
  end

  // Blank state that enters the last stage on this tick gates the colour captured with it
  assign feed_blank_n = shift_in[3*(PIPE_DLY-1)];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sr    <= {PIPE_DLY{3'b110}};
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else if (pix_ce) begin
      sr <= shift_in;
      if (feed_blank_n) begin
        VGA_R <= R_in;
        VGA_G <= G_in;
        VGA_B <= B_in;
      end else begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
    end
  end

  assign VGA_HS      = sr[SR_W-1];
  assign VGA_VS      = sr[SR_W-2];
  assign VGA_BLANK_N = sr[SR_W-3];
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing plus two shrunken-frame builds, checked every cycle
// against an arithmetic scan model and a set of hand-computed points.
module tb_vga_timing_gen;

  typedef struct {
    int d, p, hv, hfp, hs, hbp, vv, vfp, vs, vbp;
  } cfg_t;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [23:0] rgb_in [3];
  logic [2:0] pix_ce, vga_clk, frame_start, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [9:0] draw_x [3];
  logic [9:0] draw_y [3];
  logic [7:0] vga_r [3];
  logic [7:0] vga_g [3];
  logic [7:0] vga_b [3];

  int checks = 0;
  int errors = 0;
  int k;
  int phase = 0;
  int hs_low_full = 0;
  int vs_low_small = 0;
  int fs_n [3];
  int fs_k [3][2];

  always #10 Clk = ~Clk;

  // Clock edges seen since reset was last released
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) k <= 0;
    else          k <= k + 1;
  end

  vga_timing_gen u_full (
    .Clk(Clk), .Reset_n(Reset_n),
    .R_in(rgb_in[0][23:16]), .G_in(rgb_in[0][15:8]), .B_in(rgb_in[0][7:0]),
    .pix_ce(pix_ce[0]), .DrawX(draw_x[0]), .DrawY(draw_y[0]), .frame_start(frame_start[0]),
    .VGA_CLK(vga_clk[0]), .VGA_HS(vga_hs[0]), .VGA_VS(vga_vs[0]),
    .VGA_BLANK_N(vga_blank_n[0]), .VGA_SYNC_N(vga_sync_n[0]),
    .VGA_R(vga_r[0]), .VGA_G(vga_g[0]), .VGA_B(vga_b[0])
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(2), .PIPE_DLY(2)
  ) u_small (
    .Clk(Clk), .Reset_n(Reset_n),
    .R_in(rgb_in[1][23:16]), .G_in(rgb_in[1][15:8]), .B_in(rgb_in[1][7:0]),
    .pix_ce(pix_ce[1]), .DrawX(draw_x[1]), .DrawY(draw_y[1]), .frame_start(frame_start[1]),
    .VGA_CLK(vga_clk[1]), .VGA_HS(vga_hs[1]), .VGA_VS(vga_vs[1]),
    .VGA_BLANK_N(vga_blank_n[1]), .VGA_SYNC_N(vga_sync_n[1]),
    .VGA_R(vga_r[1]), .VGA_G(vga_g[1]), .VGA_B(vga_b[1])
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(4), .PIPE_DLY(1)
  ) u_p1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .R_in(rgb_in[2][23:16]), .G_in(rgb_in[2][15:8]), .B_in(rgb_in[2][7:0]),
    .pix_ce(pix_ce[2]), .DrawX(draw_x[2]), .DrawY(draw_y[2]), .frame_start(frame_start[2]),
    .VGA_CLK(vga_clk[2]), .VGA_HS(vga_hs[2]), .VGA_VS(vga_vs[2]),
    .VGA_BLANK_N(vga_blank_n[2]), .VGA_SYNC_N(vga_sync_n[2]),
    .VGA_R(vga_r[2]), .VGA_G(vga_g[2]), .VGA_B(vga_b[2])
  );

  function automatic cfg_t cfg_of(input int i);
    cfg_t c;
    if (i == 0)      c = '{2, 2, 640, 16, 96, 48, 480, 10, 2, 33};
    else if (i == 1) c = '{2, 2, 16, 2, 4, 3, 6, 1, 2, 2};
    else             c = '{4, 1, 16, 2, 4, 3, 6, 1, 2, 2};
    return c;
  endfunction

  function automatic logic [23:0] pix_colour(input int x, input int y);
    return {8'(x), 8'(y), 8'h5A};
  endfunction

  // Colour mapper stand-in: colour of the pixel issued PIPE_DLY-1 ticks before the current one
  function automatic logic [23:0] stim(input int kk, input cfg_t c);
    int ht, q, qx, qy;
    ht = c.hv + c.hfp + c.hs + c.hbp;
    q  = kk / c.d - (c.p - 1);
    if (q < 0) return 24'hFFFFFF;
    qx = q % ht;
    qy = (q / ht) % (c.vv + c.vfp + c.vs + c.vbp);
    if (qx < c.hv && qy < c.vv) return pix_colour(qx, qy);
    return 24'hFFFFFF;
  endfunction

  // Expected outputs after kk clock edges: ticks = kk/CLK_DIV, display lags by PIPE_DLY ticks
  function automatic logic [50:0] model(input int kk, input cfg_t c);
    int ht, vt, dv, t, p, px, py;
    logic pce, vck, fs, hs, vs, bn;
    logic [23:0] rgb;
    ht  = c.hv + c.hfp + c.hs + c.hbp;
    vt  = c.vv + c.vfp + c.vs + c.vbp;
    dv  = kk % c.d;
    t   = kk / c.d;
    pce = (dv == c.d - 1);
    vck = (dv >= c.d / 2);
    fs  = pce && (t % ht == ht - 1) && ((t / ht) % vt == vt - 1);
    p   = t - c.p;
    hs  = 1'b1; vs = 1'b1; bn = 1'b0; rgb = 24'h0;
    if (p >= 0) begin
      px = p % ht;
      py = (p / ht) % vt;
      hs = !(px >= c.hv + c.hfp && px < c.hv + c.hfp + c.hs);
      vs = !(py >= c.vv + c.vfp && py < c.vv + c.vfp + c.vs);
      bn = (px < c.hv) && (py < c.vv);
      if (bn) rgb = pix_colour(px, py);
    end
    return {pce, vck, fs, 10'(t % ht), 10'((t / ht) % vt), hs, vs, bn, 1'b0, rgb};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) rgb_in[i] = 24'h0;
    forever begin
      @(negedge Clk);
      for (int i = 0; i < 3; i++) rgb_in[i] = stim(k, cfg_of(i));
    end
  end

  // Per-cycle comparison against the model plus hand-computed points
  initial begin
    logic [50:0] act;
    for (int i = 0; i < 3; i++) fs_n[i] = 0;
    forever begin
      @(negedge Clk);
      for (int i = 0; i < 3; i++) begin
        act = {pix_ce[i], vga_clk[i], frame_start[i], draw_x[i], draw_y[i], vga_hs[i],
               vga_vs[i], vga_blank_n[i], vga_sync_n[i], vga_r[i], vga_g[i], vga_b[i]};
        chk($sformatf("dut%0d_k%0d", i, k), 64'(act), 64'(model(k, cfg_of(i))));
      end
      if (phase == 1 && k == 601) chk("full_x_midline", 64'(draw_x[0]), 64'd300);
      if (phase == 2) begin
        if (k < 1600 && pix_ce[0] && !vga_hs[0]) hs_low_full++;
        if (k < 550 && pix_ce[1] && !vga_vs[1]) vs_low_small++;
        for (int i = 0; i < 3; i++) begin
          if (frame_start[i]) begin
            if (fs_n[i] < 2) fs_k[i][fs_n[i]] = k;
            fs_n[i]++;
          end
        end
        case (k)
          1:    begin chk("full_ce_k1", 64'(pix_ce[0]), 64'd1);
                      chk("full_x_k1", 64'(draw_x[0]), 64'd0); end
          2:    begin chk("full_x_first_tick", 64'(draw_x[0]), 64'd1);
                      chk("full_y_first_tick", 64'(draw_y[0]), 64'd0);
                      chk("full_ce_k2", 64'(pix_ce[0]), 64'd0); end
          3:    chk("p1_ce_k3", 64'(pix_ce[2]), 64'd1);
          4:    chk("p1_ce_k4", 64'(pix_ce[2]), 64'd0);
          7:    chk("p1_ce_k7", 64'(pix_ce[2]), 64'd1);
          44:   begin chk("small_rgb_blank", 64'({vga_r[1], vga_g[1], vga_b[1]}), 64'h0);
                      chk("small_bn_blank", 64'(vga_blank_n[1]), 64'd0); end
          64:   begin chk("small_rgb_x5y1", 64'({vga_r[1], vga_g[1], vga_b[1]}), 64'h05015A);
                      chk("small_bn_x5y1", 64'(vga_blank_n[1]), 64'd1); end
          75:   chk("p1_hs_before", 64'(vga_hs[2]), 64'd1);
          76:   chk("p1_hs_first_low", 64'(vga_hs[2]), 64'd0);
          549:  begin chk("small_fs_first", 64'(frame_start[1]), 64'd1);
                      chk("small_fs_x", 64'(draw_x[1]), 64'd24);
                      chk("small_fs_y", 64'(draw_y[1]), 64'd10); end
          550:  chk("small_vs_low_ticks", 64'(vs_low_small), 64'd50);
          1099: chk("p1_fs_first", 64'(frame_start[2]), 64'd1);
          1315: chk("full_hs_before", 64'(vga_hs[0]), 64'd1);
          1316: chk("full_hs_first_low", 64'(vga_hs[0]), 64'd0);
          1507: chk("full_hs_last_low", 64'(vga_hs[0]), 64'd0);
          1508: chk("full_hs_after", 64'(vga_hs[0]), 64'd1);
          1599: begin chk("full_x_799", 64'(draw_x[0]), 64'd799);
                      chk("full_y_before_wrap", 64'(draw_y[0]), 64'd0); end
          1600: begin chk("full_x_wrap", 64'(draw_x[0]), 64'd0);
                      chk("full_y_wrap", 64'(draw_y[0]), 64'd1);
                      chk("full_hs_low_ticks", 64'(hs_low_full), 64'd96); end
          default: ;
        endcase
      end
    end
  end

  initial begin
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #3 Reset_n = 1'b1;
    phase = 1;
    for (int n = 0; n < 5000 && k != 601; n++) @(negedge Clk);
    chk("reach_mid_line", 64'(k), 64'd601);

    // Asynchronous reset in the middle of a line
    #3 Reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_hs%0d", i), 64'(vga_hs[i]), 64'd1);
      chk($sformatf("rst_vs%0d", i), 64'(vga_vs[i]), 64'd1);
      chk($sformatf("rst_bn%0d", i), 64'(vga_blank_n[i]), 64'd0);
      chk($sformatf("rst_rgb%0d", i), 64'({vga_r[i], vga_g[i], vga_b[i]}), 64'h0);
      chk($sformatf("rst_x%0d", i), 64'(draw_x[i]), 64'd0);
      chk($sformatf("rst_ce%0d", i), 64'(pix_ce[i]), 64'd0);
    end
    @(posedge Clk);
    #3 Reset_n = 1'b1;
    phase = 2;
    for (int n = 0; n < 3000 && k < 2300; n++) @(negedge Clk);
    chk("run_length", 64'(k), 64'd2300);
    #1;
    chk("full_fs_count", 64'(fs_n[0]), 64'd0);
    chk("small_fs_count", 64'(fs_n[1]), 64'd4);
    chk("small_fs_k0", 64'(fs_k[1][0]), 64'd549);
    chk("small_fs_period", 64'(fs_k[1][1] - fs_k[1][0]), 64'd550);
    chk("p1_fs_count", 64'(fs_n[2]), 64'd2);
    chk("p1_fs_period", 64'(fs_k[2][1] - fs_k[2][0]), 64'd1100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
